mux_sel_seq: RTL and testbench

MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

---
 rtl/mux_sel_seq.sv | 128 ++++++++++++
 tb/tb_mux_sel_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_seq.sv
// Round-robin select sequencer for a downstream 4:1 mux: grants one channel,
// holds its select for DWELL cycles, then captures the mux output.
module mux_sel_seq #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mux_out,
    output logic       S1,
    output logic       S0,
    output logic [3:0] grant,
    output logic       busy,
    output logic       sample,
    output logic [1:0] sample_ch,
    output logic       sample_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_ch_q, last_ch_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] grant_d;
    logic       busy_d;
    logic       sample_d;
    logic [1:0] sample_ch_d;
    logic       sample_valid_d;
    logic [1:0] winner;
    logic       do_grant;
    logic       do_release;

    // First set request bit searching upward from last+1, wrapping 3->0;
    // the last granted channel itself is considered last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign winner = rr_pick(req, last_ch_q);
    assign S1     = sel_q[1];
    assign S0     = sel_q[0];

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        last_ch_d      = last_ch_q;
        dwell_d        = dwell_q;
        grant_d        = grant;
        busy_d         = busy;
        sample_d       = sample;
        sample_ch_d    = sample_ch;
        sample_valid_d = 1'b0;
        do_grant       = 1'b0;
        do_release     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) do_grant = 1'b1;
            end
            HOLD: begin
                if (dwell_q == DWELL_LAST) begin
                    sample_d       = mux_out;
                    sample_ch_d    = sel_q;
                    sample_valid_d = 1'b1;
                    if (req != 4'b0000) do_grant = 1'b1;
                    else                do_release = 1'b1;
                end else if (!req[sel_q]) begin
                    // Requester withdrew before the capture: abandon it silently.
                    do_release = 1'b1;
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            default: do_release = 1'b1;
        endcase

        if (do_grant) begin
            state_d   = HOLD;
            sel_d     = winner;
            last_ch_d = winner;
            dwell_d   = 4'd0;
            grant_d   = 4'b0001 << winner;
            busy_d    = 1'b1;
        end else if (do_release) begin
            // Select lines keep their last value so the mux output stays stable.
            state_d = IDLE;
            dwell_d = 4'd0;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            last_ch_q    <= 2'd3;
            dwell_q      <= 4'd0;
            grant        <= 4'b0000;
            busy         <= 1'b0;
            sample       <= 1'b0;
            sample_ch    <= 2'd0;
            sample_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_ch_q    <= last_ch_d;
            dwell_q      <= dwell_d;
            grant        <= grant_d;
            busy         <= busy_d;
            sample       <= sample_d;
            sample_ch    <= sample_ch_d;
            sample_valid <= sample_valid_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed bench for mux_sel_seq: DWELL=4 and DWELL=1 instances driving a
// modelled 4:1 mux with inputs I0..I3 = 1,0,0,1.
module tb_mux_sel_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mux_data = 4'b1001;

    logic [3:0] req4 = 4'b0000;
    logic       mux_out4;
    logic       s1_4, s0_4, busy4, sample4, sv4;
    logic [3:0] grant4;
    logic [1:0] sch4;

    logic [3:0] req1 = 4'b0000;
    logic       mux_out1;
    logic       s1_1, s0_1, busy1, sample1, sv1;
    logic [3:0] grant1;
    logic [1:0] sch1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       dut1;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       sv;
        logic       smp;
        logic [1:0] sch;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign mux_out4 = mux_data[{s1_4, s0_4}];
    assign mux_out1 = mux_data[{s1_1, s0_1}];

    mux_sel_seq #(.DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .mux_out(mux_out4),
        .S1(s1_4), .S0(s0_4), .grant(grant4), .busy(busy4),
        .sample(sample4), .sample_ch(sch4), .sample_valid(sv4)
    );

    mux_sel_seq #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .mux_out(mux_out1),
        .S1(s1_1), .S0(s0_1), .grant(grant1), .busy(busy1),
        .sample(sample1), .sample_ch(sch1), .sample_valid(sv1)
    );

    task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic d1, input logic [3:0] r, input logic [3:0] g, input logic [1:0] sel,
                       input logic b, input logic sv, input logic smp, input logic [1:0] sch);
        vec_t v;
        v.dut1 = d1; v.req = r; v.grant = g; v.sel = sel;
        v.busy = b; v.sv = sv; v.smp = smp; v.sch = sch;
        vecs.push_back(v);
    endtask

    task automatic check4(input string name, input int idx, input logic [3:0] g, input logic [1:0] sel,
                          input logic b, input logic sv, input logic smp, input logic [1:0] sch);
        check({name, "_grant"}, idx, 8'(grant4), 8'(g));
        check({name, "_sel"}, idx, 8'({s1_4, s0_4}), 8'(sel));
        check({name, "_busy"}, idx, 8'(busy4), 8'(b));
        check({name, "_valid"}, idx, 8'(sv4), 8'(sv));
        check({name, "_sample"}, idx, 8'(sample4), 8'(smp));
        check({name, "_sample_ch"}, idx, 8'(sch4), 8'(sch));
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].dut1) req1 = vecs[i].req;
            else              req4 = vecs[i].req;
            @(posedge clk);
            #1;
            if (vecs[i].dut1) begin
                check("v1_grant", i, 8'(grant1), 8'(vecs[i].grant));
                check("v1_sel", i, 8'({s1_1, s0_1}), 8'(vecs[i].sel));
                check("v1_busy", i, 8'(busy1), 8'(vecs[i].busy));
                check("v1_valid", i, 8'(sv1), 8'(vecs[i].sv));
                check("v1_sample", i, 8'(sample1), 8'(vecs[i].smp));
                check("v1_sample_ch", i, 8'(sch1), 8'(vecs[i].sch));
            end else begin
                check4("v4", i, vecs[i].grant, vecs[i].sel, vecs[i].busy,
                       vecs[i].sv, vecs[i].smp, vecs[i].sch);
            end
        end
    endtask

    task automatic do_reset();
        req4 = 4'b0000;
        req1 = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check4("rst4", 0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rst1_grant", 0, 8'(grant1), 8'h00);
        check("rst1_valid", 0, 8'(sv1), 8'h00);
        check("rst1_sample_ch", 0, 8'(sch1), 8'h00);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows 0..15: single channel, abort paths, non-granted req noise (DWELL=4).
        for (int i = 0; i < 4; i++) add(0, 4'b0001, 4'b0001, 2'd0, 1, 0, 0, 2'd0);
        add(0, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, 2'd0);
        add(0, 4'b0001, 4'b0001, 2'd0, 1, 0, 1, 2'd0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 1, 2'd0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0, 1, 2'd0);
        add(0, 4'b0101, 4'b0100, 2'd2, 1, 0, 1, 2'd0);
        add(0, 4'b0110, 4'b0100, 2'd2, 1, 0, 1, 2'd0);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 0, 1, 2'd0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 1, 0, 2'd2);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0, 0, 2'd2);
        add(0, 4'b0011, 4'b0000, 2'd2, 0, 0, 0, 2'd2);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 0, 0, 2'd2);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 0, 0, 2'd2);
        // Rows 16..33: all requesting after reset, 0,1,2,3,0 rotation.
        for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0001, 2'd0, 1, 0, 0, 2'd0);
        add(0, 4'b1111, 4'b0010, 2'd1, 1, 1, 1, 2'd0);
        for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0010, 2'd1, 1, 0, 1, 2'd0);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 1, 0, 2'd1);
        for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0100, 2'd2, 1, 0, 0, 2'd1);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 1, 0, 2'd2);
        for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b1000, 2'd3, 1, 0, 0, 2'd2);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 1, 1, 2'd3);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0, 1, 2'd3);
        // Rows 34..40: DWELL=1 instance alternating 1,3 then releasing.
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 0, 0, 2'd0);
        add(1, 4'b1010, 4'b1000, 2'd3, 1, 1, 0, 2'd1);
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 1, 1, 2'd3);
        add(1, 4'b1010, 4'b1000, 2'd3, 1, 1, 0, 2'd1);
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 1, 1, 2'd3);
        add(1, 4'b0000, 4'b0000, 2'd1, 0, 1, 0, 2'd1);
        add(1, 4'b0000, 4'b0000, 2'd1, 0, 0, 0, 2'd1);

        do_reset();
        run_vecs(0, 15);
        do_reset();
        run_vecs(16, 33);

        // Reset in the middle of a channel-3 hold.
        do_reset();
        req4 = 4'b1000;
        @(posedge clk); #1;
        check4("hold3", 0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        @(posedge clk); #1;
        check4("hold3", 1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check4("async_rst", 0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        req4 = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check4("post_rst_idle", i, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        end
        req4 = 4'b1111;
        @(posedge clk); #1;
        check4("post_rst_grant", 0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check4("post_rst_hold", i, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        end
        @(posedge clk); #1;
        check4("post_rst_sample", 0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 2'd0);
        req4 = 4'b0000;

        run_vecs(34, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
